// File: rtl/regfile_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_seq                                                     |
// | Purpose  : Moore sequencer for the 8x16 register file datapath; runs one   |
// |            decoded instruction at a time and drives selects/load enables.  |
// | Options  : define REGSEQ_TRAP_EN to trap illegal opcodes in an err state.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module regfile_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic [1:0] vsel,
  output logic       write,
  output logic [1:0] alu_op,
  output logic       err
);

  localparam logic [3:0] S_WAIT   = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_WR_IMM = 4'd2;
  localparam logic [3:0] S_GET_A  = 4'd3;
  localparam logic [3:0] S_GET_B  = 4'd4;
  localparam logic [3:0] S_ALU    = 4'd5;
  localparam logic [3:0] S_STATUS = 4'd6;
  localparam logic [3:0] S_WR_REG = 4'd7;
`ifdef REGSEQ_TRAP_EN
  localparam logic [3:0] S_TRAP   = 4'd8;
`endif

  localparam logic [2:0] c_NSEL_NONE = 3'b000;
  localparam logic [2:0] c_NSEL_RN   = 3'b001;
  localparam logic [2:0] c_NSEL_RD   = 3'b010;
  localparam logic [2:0] c_NSEL_RM   = 3'b100;

  localparam logic [1:0] c_VSEL_C    = 2'b00;
  localparam logic [1:0] c_VSEL_IMM  = 2'b10;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [2:0] r_opcode;
  logic [1:0] r_op;

  logic w_is_movi;
  logic w_is_movr;
  logic w_is_add;
  logic w_is_and;
  logic w_is_cmp;
  logic w_is_mvn;

  // Decode works only on the latched copy so late input changes are ignored.
  assign w_is_movi = (r_opcode == 3'b110) && (r_op == 2'b10);
  assign w_is_movr = (r_opcode == 3'b110) && (r_op == 2'b00);
  assign w_is_add  = (r_opcode == 3'b101) && (r_op == 2'b00);
  assign w_is_and  = (r_opcode == 3'b101) && (r_op == 2'b10);
  assign w_is_cmp  = (r_opcode == 3'b101) && (r_op == 2'b01);
  assign w_is_mvn  = (r_opcode == 3'b101) && (r_op == 2'b11);

  // State register and instruction-field latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_WAIT;
      r_opcode <= 3'b000;
      r_op     <= 2'b00;
    end else begin
      r_state <= w_next;
      if ((r_state == S_WAIT) && s) begin
        r_opcode <= opcode;
        r_op     <= op;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (s) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_movi)                   w_next = S_WR_IMM;
        else if (w_is_movr || w_is_mvn)  w_next = S_GET_B;
        else if (w_is_add || w_is_and || w_is_cmp) w_next = S_GET_A;
        else begin
`ifdef REGSEQ_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_WAIT;
`endif
        end
      end
      S_WR_IMM: w_next = S_WAIT;
      S_GET_A:  w_next = S_GET_B;
      S_GET_B:  w_next = w_is_cmp ? S_STATUS : S_ALU;
      S_ALU:    w_next = S_WR_REG;
      S_STATUS: w_next = S_WAIT;
      S_WR_REG: w_next = S_WAIT;
`ifdef REGSEQ_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_WAIT;
    endcase
  end

  // Output decode
  always_comb begin
    w      = 1'b0;
    nsel   = c_NSEL_NONE;
    loada  = 1'b0;
    loadb  = 1'b0;
    asel   = 1'b0;
    bsel   = 1'b0;
    loadc  = 1'b0;
    loads  = 1'b0;
    vsel   = c_VSEL_C;
    write  = 1'b0;
    alu_op = r_op;
    err    = 1'b0;
    case (r_state)
      S_WAIT: w = 1'b1;
      S_WR_IMM: begin
        nsel  = c_NSEL_RN;
        vsel  = c_VSEL_IMM;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = c_NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = c_NSEL_RM;
        loadb = 1'b1;
      end
      S_ALU: begin
        loadc = 1'b1;
        asel  = w_is_movr || w_is_mvn;
      end
      S_STATUS: loads = 1'b1;
      S_WR_REG: begin
        nsel  = c_NSEL_RD;
        vsel  = c_VSEL_C;
        write = 1'b1;
      end
`ifdef REGSEQ_TRAP_EN
      S_TRAP: err = 1'b1;
`endif
      default: w = 1'b0;
    endcase
    // A reset landing mid-instruction must not commit anything this cycle.
    if (reset) begin
      write = 1'b0;
      loada = 1'b0;
      loadb = 1'b0;
      loadc = 1'b0;
      loads = 1'b0;
    end
  end

endmodule
`default_nettype wire
